// File: rtl/duty_ramp_gen.sv
// duty_ramp_gen: slews the PWM duty toward a latched target, one step per tick.
// Optional completion interrupt behind `DUTY_RAMP_IRQ_EN.
module duty_ramp_gen #(
  parameter int            DW      = 16,
  parameter logic [DW-1:0] INIT_DC = '0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [DW-1:0] i_target,
  input  logic          i_target_valid,
  output logic          o_target_ready,
  input  logic [DW-1:0] i_step,
  input  logic [DW-1:0] i_period,
  input  logic          i_tick,
  input  logic          i_abort,
`ifdef DUTY_RAMP_IRQ_EN
  input  logic          i_irq_clr,
  output logic          o_irq,
`endif
  output logic [DW-1:0] o_dc,
  output logic          o_dc_valid,
  output logic          o_busy,
  output logic          o_at_target
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state_q, state_n;
  logic [DW-1:0] dc_q, dc_n;
  logic [DW-1:0] target_q, target_n;
  logic          ready_q;
  logic          valid_q;
  logic          at_tgt_q;

  logic          accept;
  logic [DW-1:0] step_eff;
  logic [DW-1:0] tgt_clamp;
  logic [DW-1:0] tgt_eff;
  logic [DW-1:0] diff;
  logic [DW-1:0] stepped;
  logic          up;

  assign accept   = i_target_valid & ready_q;
  assign step_eff = (i_step == '0) ?
                    {{(DW-1){1'b0}}, 1'b1} : i_step;
  assign tgt_clamp = (i_target > i_period) ?
                     i_period : i_target;
  // a fresh target steers the same-cycle tick
  assign tgt_eff = accept ? tgt_clamp : target_q;
  assign up      = tgt_eff > dc_q;
  assign diff    = up ? (tgt_eff - dc_q) : (dc_q - tgt_eff);
  assign stepped = (diff <= step_eff) ? tgt_eff :
                   (up ? (dc_q + step_eff) : (dc_q - step_eff));

  always_comb begin
    state_n  = state_q;
    dc_n     = dc_q;
    target_n = target_q;
    if (accept) begin
      target_n = tgt_clamp;
      if (i_tick) dc_n = stepped;
      state_n = (dc_n == tgt_clamp) ? IDLE : RAMP;
    end else begin
      unique case (state_q)
        RAMP: begin
          if (i_abort) begin
            state_n = HOLD;
          end else begin
            if (i_tick) dc_n = stepped;
            if (dc_n == target_q) state_n = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      dc_q     <= INIT_DC;
      target_q <= INIT_DC;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      at_tgt_q <= 1'b1;
    end else begin
      state_q  <= state_n;
      dc_q     <= dc_n;
      target_q <= target_n;
      ready_q  <= 1'b1;
      valid_q  <= (dc_n != dc_q);
      at_tgt_q <= (dc_n == target_n) && (state_n != HOLD);
    end
  end

  assign o_target_ready = ready_q;
  assign o_dc           = dc_q;
  assign o_dc_valid     = valid_q;
  assign o_busy         = (state_q == RAMP);
  assign o_at_target    = at_tgt_q;

`ifdef DUTY_RAMP_IRQ_EN
  logic irq_q;
  logic irq_set;

  assign irq_set = (state_q == RAMP) && (state_n == IDLE);

  // set beats a coincident clear
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      irq_q <= 1'b0;
    end else if (irq_set) begin
      irq_q <= 1'b1;
    end else if (i_irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign o_irq = irq_q;
`endif

endmodule

// File: doc/duty_ramp_gen.md
Name: duty_ramp_gen

Overview:
- Upstream feeder for the PWM timer's external duty-cycle input (i_DC / i_DC_valid).
- Accepts a target duty value and slews the PWM duty toward it in fixed steps, one step per update tick. This gives soft-start and soft-change without duty jumps.
- The tick is normally the PWM period-end strobe. Runs in the PWM clock domain.

Parameters:
- DW, 16, width of duty, period and step values.
- INIT_DC, 0, duty value held on o_dc after reset.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-low
- i_target  in  DW  requested duty value
- i_target_valid  in  1  target offer
- o_target_ready  out  1  target accepted when valid & ready
- i_step  in  DW  increment per tick; 0 is treated as 1
- i_period  in  DW  PWM period; targets are clamped to this value
- i_tick  in  1  one-cycle update strobe
- i_abort  in  1  freeze the ramp at the current value
- o_dc  out  DW  current duty, drives PWM i_DC
- o_dc_valid  out  1  one-cycle pulse whenever o_dc changes
- o_busy  out  1  ramp in progress
- o_at_target  out  1  o_dc equals the latched target

Behaviour:
- Reset (i_rst=0, async):
  - FSM=IDLE, o_dc=INIT_DC, target_q=INIT_DC.
  - o_dc_valid=0, o_busy=0, o_at_target=1.
  - o_target_ready=0 while reset is asserted; 1 from the first clock edge after release.
- o_target_ready = 1 in IDLE and RAMP. New targets may override a ramp in progress.
- Target latch on valid & ready:
  - target_q <= min(i_target, i_period), unsigned compare.
  - FSM -> RAMP if the clamped value differs from o_dc, else stays IDLE.
- FSM states:
  - IDLE: o_busy=0. Waits for a target.
  - RAMP: o_busy=1. On each i_tick, o_dc moves toward target_q by step_eff = (i_step==0) ? 1 : i_step.
    - Up: if target_q - o_dc <= step_eff, then o_dc <= target_q; else o_dc <= o_dc + step_eff.
    - Down: mirror of up, using o_dc - target_q.
    - All subtraction is done on the unsigned difference first, so no wrap-around is possible.
    - When o_dc reaches target_q: FSM -> IDLE, o_at_target=1 on the next cycle.
  - HOLD: entered from RAMP on i_abort=1. o_dc frozen, o_busy=0, o_at_target=0.
    - Exits on the next accepted target, which goes through the normal latch rule (RAMP, or IDLE if equal).
    - i_abort in IDLE has no effect.
- o_dc_valid: registered, high for exactly one cycle in the cycle after any o_dc update. It never pulses when o_dc is unchanged.
- Simultaneous target accept and i_tick in RAMP or IDLE: the new clamped target is latched, and that same tick steps toward the new target in the same cycle.
- Simultaneous i_abort and i_tick: abort wins and o_dc is not updated.
- Simultaneous i_abort and target accept: the target wins and the abort is ignored.
- i_period lowered below the current o_dc during IDLE: no action; clamping applies only at target latch.
- o_at_target = (o_dc == target_q) && FSM != HOLD, registered.
- Latency: target accept to first possible o_dc change = the first i_tick at or after the accept cycle. o_dc is updated at that tick's edge.

Optional Feature:
- Macro DUTY_RAMP_IRQ_EN.
- Defined:
  - Adds port i_irq_clr (in, 1) and port o_irq (out, 1).
  - o_irq is sticky and set the cycle after a RAMP -> IDLE completion. It is not set by an abort.
  - Cleared by i_irq_clr=1. If set and clear occur in the same cycle, set wins. Reset value 0.
- Not defined: neither port exists and there is no interrupt logic.

Test Plan:
- Reset with INIT_DC=0 -> o_dc=0, o_busy=0, o_at_target=1, o_dc_valid=0; after release, o_target_ready=1.
- Up-ramp: target=500, step=100, period=1000, 6 ticks.
  - o_dc = 100, 200, 300, 400, 500, 500.
  - o_dc_valid pulses 5 times.
  - o_busy drops after the 5th tick; o_at_target=1.
- Non-multiple and clamp: from 0, target=1200, period=1000, step=300 -> o_dc = 300, 600, 900, 1000, then IDLE. Then target=50 -> o_dc = 700, 400, 100, 50.
- Step zero and override: step=0, target=3 from 0 -> 1, 2. Then target=0 is accepted in the same cycle as the third tick -> o_dc=1 on that edge, then 0 on the next tick.
- Abort: ramping 0 -> 800 with step=100 and i_abort asserted at o_dc=300 together with a tick -> o_dc stays 300, FSM=HOLD, o_at_target=0, no o_dc_valid pulse. Then target=300 -> IDLE, o_at_target=1.
- DUTY_RAMP_IRQ_EN: ramp completes -> o_irq=1 and stays high. i_irq_clr pulse -> o_irq=0. Clear coincident with a completion -> o_irq stays 1.
